// File: rtl/snax_alu_acc_if.sv
// Stream-side bundle of the SNAX ALU output accumulator: PE result input plus registered output port.
interface snax_alu_acc_if #(
  parameter int DataWidth = 64
);
  logic [2*DataWidth-1:0] c_i;
  logic                   c_valid_i;
  logic                   c_ready_o;
  logic                   acc_ready_o;
  logic [2*DataWidth-1:0] out_o;
  logic                   out_valid_o;
  logic                   out_ready_i;

  modport slave (
    input  c_i, c_valid_i, out_ready_i,
    output c_ready_o, acc_ready_o, out_o, out_valid_o
  );

  modport master (
    output c_i, c_valid_i, out_ready_i,
    input  c_ready_o, acc_ready_o, out_o, out_valid_o
  );
endinterface

// File: rtl/snax_alu_acc.sv
// Output accumulator behind the SNAX ALU PE: pass-through or sums acc_len beats per output,
// emitting num_out results through a registered valid/ready slot.
module snax_alu_acc #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                acc_en_i,
  input  logic [CntWidth-1:0] acc_len_i,
  input  logic [CntWidth-1:0] num_out_i,
  output logic                busy_o,
  snax_alu_acc_if.slave       io
);

  localparam int W = 2 * DataWidth;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [W-1:0]        out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [CntWidth-1:0] beat_q, beat_d;
  logic [CntWidth-1:0] outcnt_q, outcnt_d;
  logic [CntWidth-1:0] len_q, len_d;
  logic [CntWidth-1:0] numout_q, numout_d;

  logic finalBeat;
  logic outHs;
  logic cReady;
  logic cAccept;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      beat_q      <= '0;
      outcnt_q    <= '0;
      len_q       <= '0;
      numout_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      beat_q      <= beat_d;
      outcnt_q    <= outcnt_d;
      len_q       <= len_d;
      numout_q    <= numout_d;
    end
  end

  // The output slot only gates final beats; c_ready depends on state and out_ready, never on c_valid.
  always_comb begin
    finalBeat = (beat_q == CntWidth'(len_q - 1'b1));
    outHs     = out_valid_q && io.out_ready_i;
    cReady    = (state_q == RUN) && (!finalBeat || !out_valid_q || io.out_ready_i);
    cAccept   = cReady && io.c_valid_i;

    state_d     = state_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    beat_d      = beat_q;
    outcnt_d    = outcnt_q;
    len_d       = len_q;
    numout_d    = numout_q;

    if (outHs) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_i && (num_out_i != '0)) begin
          state_d  = RUN;
          numout_d = num_out_i;
          len_d    = (!acc_en_i || (acc_len_i == '0)) ? CntWidth'(1) : acc_len_i;
          acc_d    = '0;
          beat_d   = '0;
          outcnt_d = '0;
        end
      end
      RUN: begin
        if (cAccept) begin
          if (finalBeat) begin
            out_d       = acc_q + io.c_i;
            out_valid_d = 1'b1;
            acc_d       = '0;
            beat_d      = '0;
            outcnt_d    = outcnt_q + 1'b1;
            if (outcnt_q == CntWidth'(numout_q - 1'b1)) begin
              state_d = DRAIN;
            end
          end else begin
            acc_d  = acc_q + io.c_i;
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (outHs) begin
          state_d  = IDLE;
          acc_d    = '0;
          beat_d   = '0;
          outcnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.c_ready_o   = cReady;
  assign io.acc_ready_o = cReady;
  assign io.out_o       = out_q;
  assign io.out_valid_o = out_valid_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_snax_alu_acc.sv
// Randomised scoreboard bench for snax_alu_acc: a group-sum model fills the expected queue on
// every accepted beat and a monitor pops and compares on every output handshake.
module tb_snax_alu_acc;

  localparam int DataWidth = 64;
  localparam int CntWidth  = 8;
  localparam int W         = 2 * DataWidth;

  logic                clk;
  logic                rst;
  logic                start;
  logic                accEn;
  logic [CntWidth-1:0] accLen;
  logic [CntWidth-1:0] numOut;
  logic                busy;

  snax_alu_acc_if #(.DataWidth(DataWidth)) bus ();

  snax_alu_acc #(.DataWidth(DataWidth), .CntWidth(CntWidth)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .acc_en_i  (accEn),
    .acc_len_i (accLen),
    .num_out_i (numOut),
    .busy_o    (busy),
    .io        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] sbQ[$];
  logic [W-1:0] dataQ[$];
  logic [W-1:0] modelSum;
  int           modelBeat;
  int           modelLen;
  int           acceptCnt;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: every modelLen accepted beats form one output equal to their modulo-2^W sum.
  task automatic modelAccept(input logic [W-1:0] d);
    acceptCnt++;
    modelSum = modelSum + d;
    modelBeat++;
    if (modelBeat == modelLen) begin
      sbQ.push_back(modelSum);
      modelSum  = '0;
      modelBeat = 0;
    end
    if (dataQ.size() > 0) void'(dataQ.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid_o) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected output", bus.out_o, '0);
        if (bus.out_o == '0) begin
          bad++;
          $display("[TB] FAIL unexpected output: got valid with no pending result, expected none");
        end
      end else begin
        checkOutput("out_o vs model", bus.out_o, sbQ[0]);
        if (bus.out_ready_i) void'(sbQ.pop_front());
      end
    end
    if (!rst && busy) checkOutput("acc_ready equals c_ready", W'(bus.acc_ready_o), W'(bus.c_ready_o));
  end

  task automatic step();
    @(negedge clk);
    if (!rst && bus.c_valid_i && bus.c_ready_o) modelAccept(bus.c_i);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int en, input int len, input int num);
    start  = 1'b1;
    accEn  = en[0];
    accLen = CntWidth'(len);
    numOut = CntWidth'(num);
    checkOutput("c_ready in start cycle", W'(bus.c_ready_o), '0);
    step();
    start  = 1'b0;
    accEn  = $urandom_range(0, 1) == 1;
    accLen = CntWidth'($urandom);
    numOut = CntWidth'($urandom);
    checkOutput("busy after start", W'(busy), W'(num != 0));
    if (num != 0) begin
      modelLen  = (en == 0 || len == 0) ? 1 : len;
      modelSum  = '0;
      modelBeat = 0;
    end
  endtask

  task automatic feedBeats(input int n, input int validPct, input int readyPct);
    int target;
    int budget;
    target = acceptCnt + n;
    budget = 4000;
    while (acceptCnt < target && budget > 0) begin
      bus.c_valid_i   = $urandom_range(0, 99) < validPct;
      bus.c_i         = (dataQ.size() > 0) ? dataQ[0] : rand128();
      bus.out_ready_i = $urandom_range(0, 99) < readyPct;
      step();
      budget--;
    end
    if (budget == 0) begin
      bad++;
      total++;
      $display("[TB] FAIL feed timeout: accepted %0d beats, required %0d", acceptCnt, target);
    end
    bus.c_valid_i = 1'b0;
  endtask

  task automatic finishTxn();
    int k;
    bus.c_valid_i   = 1'b0;
    bus.out_ready_i = 1'b1;
    k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    checkOutput("busy after txn", W'(busy), '0);
    checkOutput("pending results", W'(sbQ.size()), '0);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    accEn           = 1'b0;
    accLen          = '0;
    numOut          = '0;
    bus.c_i         = '0;
    bus.c_valid_i   = 1'b0;
    bus.out_ready_i = 1'b0;
    modelSum        = '0;
    modelBeat       = 0;
    modelLen        = 1;
    acceptCnt       = 0;

    #12;
    checkOutput("reset out_valid", W'(bus.out_valid_o), '0);
    checkOutput("reset c_ready", W'(bus.c_ready_o), '0);
    checkOutput("reset acc_ready", W'(bus.acc_ready_o), '0);
    checkOutput("reset busy", W'(busy), '0);
    checkOutput("reset out_o", bus.out_o, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pass-through 5,7,9: each output valid the cycle after its accept.
    applyStimulus(0, 0, 3);
    dataQ = '{W'(5), W'(7), W'(9)};
    for (int i = 0; i < 3; i++) begin
      bus.c_valid_i   = 1'b1;
      bus.out_ready_i = 1'b1;
      bus.c_i         = dataQ[0];
      step();
      checkOutput("pass-through valid after accept", W'(bus.out_valid_o), W'(1));
    end
    finishTxn();

    // Accumulate 1..8 in groups of 4, then hold the last result to observe DRAIN.
    applyStimulus(1, 4, 2);
    for (int i = 1; i <= 8; i++) dataQ.push_back(W'(i));
    feedBeats(8, 100, 100);
    bus.out_ready_i = 1'b0;
    bus.c_valid_i   = 1'b1;
    #1;
    checkOutput("c_ready in DRAIN", W'(bus.c_ready_o), '0);
    step();
    checkOutput("c_ready in DRAIN held", W'(bus.c_ready_o), '0);
    checkOutput("busy in DRAIN", W'(busy), W'(1));
    finishTxn();

    // Backpressure with acc_len=2: final beats wait for the slot, non-final ones do not.
    applyStimulus(1, 2, 2);
    bus.out_ready_i = 1'b0;
    bus.c_valid_i   = 1'b1;
    bus.c_i = W'(1); checkOutput("bp beat0 ready", W'(bus.c_ready_o), W'(1)); step();
    bus.c_i = W'(2); checkOutput("bp beat1 ready", W'(bus.c_ready_o), W'(1)); step();
    bus.c_i = W'(3); checkOutput("bp nonfinal ready", W'(bus.c_ready_o), W'(1)); step();
    bus.c_i = W'(4); checkOutput("bp final blocked", W'(bus.c_ready_o), '0); step();
    checkOutput("bp final still blocked", W'(bus.c_ready_o), '0); step();
    bus.out_ready_i = 1'b1;
    #1;
    checkOutput("bp final released", W'(bus.c_ready_o), W'(1));
    step();
    finishTxn();

    // Wrap-around: all-ones plus 2 discards the carry.
    applyStimulus(1, 2, 1);
    dataQ = '{{W{1'b1}}, W'(2)};
    feedBeats(2, 100, 100);
    finishTxn();

    // acc_len=0 degenerates to pass-through.
    applyStimulus(1, 0, 2);
    feedBeats(2, 80, 100);
    finishTxn();

    // num_out=0 start is ignored.
    applyStimulus(1, 3, 0);
    step();
    checkOutput("num_out=0 stays idle", W'(busy), '0);

    // start during RUN with different config is ignored.
    applyStimulus(1, 3, 2);
    feedBeats(2, 100, 100);
    start  = 1'b1;
    accEn  = 1'b0;
    numOut = CntWidth'(5);
    step();
    start = 1'b0;
    feedBeats(4, 100, 100);
    finishTxn();

    // Reset after 2 of 4 beats discards the partial sum.
    applyStimulus(1, 4, 1);
    dataQ = '{W'(100), W'(200)};
    feedBeats(2, 100, 100);
    bus.c_valid_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid reset out_valid", W'(bus.out_valid_o), '0);
    checkOutput("mid reset c_ready", W'(bus.c_ready_o), '0);
    checkOutput("mid reset busy", W'(busy), '0);
    bus.c_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    modelSum  = '0;
    modelBeat = 0;
    sbQ.delete();
    dataQ.delete();
    @(posedge clk);
    #1;
    applyStimulus(1, 4, 1);
    dataQ = '{W'(1), W'(1), W'(1), W'(1)};
    feedBeats(4, 100, 100);
    finishTxn();

    // Randomised transactions with valid gaps and output backpressure.
    for (int t = 0; t < 8; t++) begin
      int en;
      int len;
      int num;
      int effLen;
      en     = $urandom_range(0, 1);
      len    = $urandom_range(0, 5);
      num    = $urandom_range(1, 4);
      effLen = (en == 0 || len == 0) ? 1 : len;
      applyStimulus(en, len, num);
      feedBeats(num * effLen, 70, 60);
      finishTxn();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
